// File: rtl/gate_selftest_pkg.sv
// ---------------------------------------------------------------------------
// gate_selftest_pkg
// Shared definitions for the basic-gate self-test sequencer:
//   - state_e        : sequencer FSM states
//   - NUM_GATES      : number of gate outputs checked (y1..y7)
//   - Y*_BIT         : bit position of each gate output inside y[6:0]
//   - GOLDEN[0:3]    : expected y[6:0] for vector index {a,b} = 0..3
//   - golden_eqn()   : golden value from the gate equations (reference form
//                      of the GOLDEN table)
// ---------------------------------------------------------------------------
package gate_selftest_pkg;

  localparam int NUM_GATES = 7;

  localparam int Y1_BIT = 0;  // a & b
  localparam int Y2_BIT = 1;  // a | b
  localparam int Y3_BIT = 2;  // ~(a & b)
  localparam int Y4_BIT = 3;  // ~(a | b)
  localparam int Y5_BIT = 4;  // a ^ b
  localparam int Y6_BIT = 5;  // ~(a ^ b)
  localparam int Y7_BIT = 6;  // ~a

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Indexed by {a,b}
  localparam logic [NUM_GATES-1:0] GOLDEN [0:3] = '{7'h6C, 7'h56, 7'h16, 7'h23};

  function automatic logic [NUM_GATES-1:0] golden_eqn(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g         = 7'h00;
    g[Y1_BIT] = a & b;
    g[Y2_BIT] = a | b;
    g[Y3_BIT] = ~(a & b);
    g[Y4_BIT] = ~(a | b);
    g[Y5_BIT] = a ^ b;
    g[Y6_BIT] = ~(a ^ b);
    g[Y7_BIT] = ~a;
    return g;
  endfunction

endpackage

// File: rtl/gate_selftest_seq_golden_lut.sv
// ---------------------------------------------------------------------------
// gate_golden_lut
// Combinational lookup of the expected gate-unit outputs for one vector.
// Ports:
//   i_idx     in  2  vector index, {a,b}
//   o_golden  out 7  expected y[6:0] (bit0 = y1 .. bit6 = y7)
// ---------------------------------------------------------------------------
module gate_golden_lut
  import gate_selftest_pkg::*;
(
  input  logic [1:0]           i_idx,
  output logic [NUM_GATES-1:0] o_golden
);

  // Table lookup of the golden vector
  always_comb begin
    o_golden = GOLDEN[0];
    case (i_idx)
      2'd0:    o_golden = GOLDEN[0];
      2'd1:    o_golden = GOLDEN[1];
      2'd2:    o_golden = GOLDEN[2];
      2'd3:    o_golden = GOLDEN[3];
      default: o_golden = GOLDEN[0];
    endcase
  end

endmodule

// File: rtl/gate_selftest_seq.sv
// ---------------------------------------------------------------------------
// gate_selftest_seq
// Built-in self-test controller for the shared two-input basic-gate unit.
// On start it drives the four (a,b) vectors in order 00,01,10,11, waits
// SETTLE_CYCLES after each drive, samples the seven gate outputs and checks
// them against the golden table. Reports pass, a saturating count of
// mismatching vectors and the OR of all per-output differences.
//
// Parameters:
//   SETTLE_CYCLES  wait cycles between drive and sample (0 allowed)
//   ERR_CNT_W      width of err_cnt (saturates at all-ones)
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   start      in   1          starts one sweep (sampled in IDLE only)
//   a_o, b_o   out  1          registered drive to gate unit inputs
//   y_i        in   7          gate unit outputs, bit0 = y1 .. bit6 = y7
//   busy       out  1          high whenever not IDLE
//   done       out  1          one-cycle pulse at sweep end
//   pass       out  1          last sweep had no mismatch
//   err_cnt    out  ERR_CNT_W  mismatching vectors in last sweep
//   fail_mask  out  7          OR of (y_i ^ golden) over last sweep
// Optional (macro GATE_SELFTEST_SNAPSHOT_EN):
//   fail_valid out  1          a mismatch was captured this sweep
//   fail_vec   out  2          vector index of the first mismatch
//   fail_y     out  7          y_i observed at the first mismatch
// ---------------------------------------------------------------------------
module gate_selftest_seq
  import gate_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 a_o,
  output logic                 b_o,
  input  logic [NUM_GATES-1:0] y_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [NUM_GATES-1:0] fail_mask
`ifdef GATE_SELFTEST_SNAPSHOT_EN
  ,
  output logic                 fail_valid,
  output logic [1:0]           fail_vec,
  output logic [NUM_GATES-1:0] fail_y
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES <= 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [1:0]            r_idx;
  logic [CNT_W-1:0]      r_settle_cnt;
  logic                  r_a;
  logic                  r_b;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [ERR_CNT_W-1:0]  r_err;
  logic [NUM_GATES-1:0]  r_mask;
  logic [NUM_GATES-1:0]  w_golden;
  logic [NUM_GATES-1:0]  w_diff;
  logic                  w_mismatch;
  logic [ERR_CNT_W-1:0]  w_err_nxt;
  logic [1:0]            w_idx_nxt;

  gate_golden_lut u_lut (
    .i_idx    (r_idx),
    .o_golden (w_golden)
  );

  // Compare the sampled gate outputs and form the saturating count update
  always_comb begin
    w_diff     = y_i ^ w_golden;
    w_mismatch = |w_diff;
    w_idx_nxt  = r_idx + 2'd1;
    if (w_mismatch && (r_err != ERR_MAX)) begin
      w_err_nxt = r_err + 1'b1;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = DRIVE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DRIVE: begin
        if (SETTLE_CYCLES == 0) begin
          w_state_nxt = CHECK;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = CHECK;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      CHECK: begin
        if (r_idx == 2'd3) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRIVE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: vector drive, settle timer, result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= 2'd0;
      r_settle_cnt <= '0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_mask       <= '0;
    end else begin
      // busy/done are registered from the next state so they line up with it
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx  <= 2'd0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_err  <= '0;
            r_mask <= '0;
            r_pass <= 1'b0;
          end
        end
        DRIVE:  r_settle_cnt <= '0;
        SETTLE: r_settle_cnt <= r_settle_cnt + 1'b1;
        CHECK: begin
          r_err  <= w_err_nxt;
          r_mask <= r_mask | w_diff;
          if (r_idx != 2'd3) begin
            r_idx <= w_idx_nxt;
            r_a   <= w_idx_nxt[1];
            r_b   <= w_idx_nxt[0];
          end else begin
            // Uses the count including this last vector so pass is valid with done
            r_pass <= (w_err_nxt == '0);
          end
        end
        DONE: begin
          r_a <= 1'b0;
          r_b <= 1'b0;
        end
        default: begin
          r_idx <= 2'd0;
        end
      endcase
    end
  end

`ifdef GATE_SELFTEST_SNAPSHOT_EN
  logic                 r_fail_valid;
  logic [1:0]           r_fail_vec;
  logic [NUM_GATES-1:0] r_fail_y;

  // Capture the first mismatching vector of a sweep; later ones are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 2'd0;
      r_fail_y     <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 2'd0;
      r_fail_y     <= '0;
    end else if ((r_state == CHECK) && w_mismatch && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_vec   <= r_idx;
      r_fail_y     <= y_i;
    end
  end

  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;
  assign fail_y     = r_fail_y;
`endif

  assign a_o       = r_a;
  assign b_o       = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign fail_mask = r_mask;

endmodule

// File: tb/tb_gate_selftest_seq.sv
// ---------------------------------------------------------------------------
// tb_gate_selftest_seq
// Directed bench for gate_selftest_seq. Three instances share clk/rst_n:
//   u_dut0 defaults, u_dut1 ERR_CNT_W=2, u_dut2 SETTLE_CYCLES=0.
// Each is fed by a behavioural gate unit with a selectable fault.
// ---------------------------------------------------------------------------
module tb_gate_selftest_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic [1:0] fault0, fault1, fault2;

  logic       a0, b0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [6:0] mask0, y0;
  logic       a1, b1, busy1, done1, pass1;
  logic [1:0] err1;
  logic [6:0] mask1, y1;
  logic       a2, b2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [6:0] mask2, y2;
`ifdef GATE_SELFTEST_SNAPSHOT_EN
  logic       fv0, fv1, fv2;
  logic [1:0] fvec0, fvec1, fvec2;
  logic [6:0] fy0, fy1, fy2;
`endif

  logic [1:0] lut_idx;
  logic [6:0] lut_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural gate unit: 0 good, 1 y1 stuck-0, 2 y7 = a, 3 y5 = 0 when a!=b
  function automatic logic [6:0] gate_unit(input logic a, input logic b, input logic [1:0] f);
    logic [6:0] y;
    y = {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    case (f)
      2'd1:    y[0] = 1'b0;
      2'd2:    y[6] = a;
      2'd3:    if (a ^ b) y[4] = 1'b0;
      default: ;
    endcase
    return y;
  endfunction

  assign y0 = gate_unit(a0, b0, fault0);
  assign y1 = gate_unit(a1, b1, fault1);
  assign y2 = gate_unit(a2, b2, fault2);

  gate_selftest_seq u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_o(a0), .b_o(b0), .y_i(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_mask(mask0)
`ifdef GATE_SELFTEST_SNAPSHOT_EN
    , .fail_valid(fv0), .fail_vec(fvec0), .fail_y(fy0)
`endif
  );

  gate_selftest_seq #(.ERR_CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_o(a1), .b_o(b1), .y_i(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_mask(mask1)
`ifdef GATE_SELFTEST_SNAPSHOT_EN
    , .fail_valid(fv1), .fail_vec(fvec1), .fail_y(fy1)
`endif
  );

  gate_selftest_seq #(.SETTLE_CYCLES(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_o(a2), .b_o(b2), .y_i(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_mask(mask2)
`ifdef GATE_SELFTEST_SNAPSHOT_EN
    , .fail_valid(fv2), .fail_vec(fvec2), .fail_y(fy2)
`endif
  );

  gate_golden_lut u_lut (.i_idx(lut_idx), .o_golden(lut_out));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs(input int w);
    case (w)
      0:       return {a0, b0, busy0, done0, pass0, mask0[5:0]};
      1:       return {a1, b1, busy1, done1, pass1, mask1[5:0]};
      default: return {a2, b2, busy2, done2, pass2, mask2[5:0]};
    endcase
  endfunction

  function automatic logic [2:0] get_err(input int w);
    case (w)
      0:       return err0;
      1:       return {1'b0, err1};
      default: return err2;
    endcase
  endfunction

  function automatic logic [6:0] get_mask(input int w);
    case (w)
      0:       return mask0;
      1:       return mask1;
      default: return mask2;
    endcase
  endfunction

  // Launch a sweep with a one-cycle start pulse and check timing, vectors and results
  task automatic sweep(input string tag, input int w, input int per, input int exp_edges,
                       input logic [2:0] exp_err, input logic [6:0] exp_mask, input logic exp_pass);
    int edges, ab_err, busy_err;
    logic [10:0] o;
    logic [1:0]  exp_ab;
    @(negedge clk);
    start_v[w] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[w] = 1'b0;
    edges = 0; ab_err = 0; busy_err = 0;
    o = outs(w);
    while (edges < 100 && !o[7]) begin
      exp_ab = 2'(edges / per);
      if (o[10:9] != exp_ab) ab_err++;
      if (!o[8]) busy_err++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      o = outs(w);
    end
    chk({tag, "_done_edge"}, edges, exp_edges);
    chk({tag, "_ab_seq"}, ab_err, 0);
    chk({tag, "_busy_held"}, busy_err, 0);
    chk({tag, "_err_cnt"}, get_err(w), exp_err);
    chk({tag, "_fail_mask"}, get_mask(w), exp_mask);
    chk({tag, "_pass"}, o[6], exp_pass);
    @(posedge clk);
    @(negedge clk);
    o = outs(w);
    chk({tag, "_idle_ab_busy_done"}, o[10:7], 4'b0000);
    chk({tag, "_pass_hold"}, o[6], exp_pass);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] golden_tbl [4];
    int n_done, busy_low, first_done, second_done;
    golden_tbl = '{7'h6C, 7'h56, 7'h16, 7'h23};
    rst_n   = 1'b0;
    start_v = 3'b000;
    fault0  = 2'd0; fault1 = 2'd0; fault2 = 2'd0;
    lut_idx = 2'd0;
    repeat (2) @(negedge clk);

    // Reset state of all instances
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("reset_outs%0d", w), {outs(w), get_err(w), get_mask(w)}, 21'd0);
    end
    rst_n = 1'b1;

    // Golden lookup against the hand-derived table
    for (int i = 0; i < 4; i++) begin
      lut_idx = 2'(i);
      #1;
      chk($sformatf("lut%0d", i), lut_out, golden_tbl[i]);
    end

    // 1: good unit, defaults
    sweep("s1_good", 0, 3, 12, 3'd0, 7'h00, 1'b1);
    // 2: y1 stuck-at-0, fails only at ab=11
    fault0 = 2'd1;
    sweep("s2_y1sa0", 0, 3, 12, 3'd1, 7'h01, 1'b0);
    // 3: y7 as buffer, all four vectors fail; saturates with 2-bit counter
    fault0 = 2'd2;
    sweep("s3_y7buf", 0, 3, 12, 3'd4, 7'h40, 1'b0);
    fault1 = 2'd2;
    sweep("s3_y7buf_w2", 1, 3, 12, 3'd3, 7'h40, 1'b0);

    // 4: start held through two sweeps, extra pulses while busy
    fault0 = 2'd1;
    @(negedge clk);
    start_v[0] = 1'b1;
    n_done = 0; busy_low = 0; first_done = -1; second_done = -1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0) begin
        n_done++;
        if (n_done == 1) begin
          first_done = e;
          chk("s4_sweep1_err", err0, 3'd1);
          chk("s4_sweep1_mask", mask0, 7'h01);
          fault0 = 2'd0;
        end else begin
          second_done = e;
          chk("s4_sweep2_err", err0, 3'd0);
          chk("s4_sweep2_mask", mask0, 7'h00);
        end
      end
      if (!busy0 && e < 26) busy_low++;
      if (e == 13) chk("s4_sweep1_pass", pass0, 1'b0);
      if (e == 27) chk("s4_sweep2_pass", pass0, 1'b1);
      if (e >= 16 && e <= 24) start_v[0] = ((e % 2) == 0);
      if (e == 25) start_v[0] = 1'b0;
    end
    chk("s4_done_count", n_done, 2);
    chk("s4_first_done", first_done, 12);
    chk("s4_second_done", second_done, 26);
    chk("s4_busy_low_cycles", busy_low, 1);
    chk("s4_final_busy", busy0, 1'b0);

    // 5: reset during CHECK of idx=2
    fault0 = 2'd2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("s5_partial_err", err0, 3'd2);
    chk("s5_partial_ab", {a0, b0}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("s5_reset_outs", {outs(0), err0, mask0}, 21'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    fault0 = 2'd0;
    sweep("s5_after_rst", 0, 3, 12, 3'd0, 7'h00, 1'b1);

    // 7: zero settle cycles
    sweep("s7_settle0", 2, 2, 8, 3'd0, 7'h00, 1'b1);

`ifdef GATE_SELFTEST_SNAPSHOT_EN
    // 6: y5 drops at ab=01 and ab=10; first failure is captured
    fault0 = 2'd3;
    sweep("s6_snap", 0, 3, 12, 3'd2, 7'h10, 1'b0);
    chk("s6_fail_valid", fv0, 1'b1);
    chk("s6_fail_vec", fvec0, 2'b01);
    chk("s6_fail_y", fy0, 7'h46);
    fault0 = 2'd0;
    sweep("s6_clear", 0, 3, 12, 3'd0, 7'h00, 1'b1);
    chk("s6_cleared_valid", fv0, 1'b0);
    chk("s6_cleared_y", fy0, 7'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
